// File: rtl/celery_pkg.sv
// Shared types and constants for the celery triangle pipeline: the setup-stage
// triangle record and the raster dispatcher state encoding.
package celery_pkg;

  localparam int DISPATCH_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    D_IDLE,
    D_ISSUE,
    D_RUN
  } dispatch_state_t;

  typedef struct packed {
    logic        valid;
    logic [11:0] tri_id;
    logic [15:0] x0;
    logic [15:0] y0;
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] x2;
    logic [15:0] y2;
  } triangle_setup_t;

endpackage

// File: rtl/tri_fifo.sv
// Triangle queue for the raster dispatcher: power-of-two circular buffer with
// wrapping pointers, an occupancy counter and a synchronous flush.
module tri_fifo
  import celery_pkg::*;
#(
  parameter int  DEPTH = DISPATCH_DEPTH_DEFAULT,
  parameter type T     = triangle_setup_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output T                         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so the increment wraps on its own.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; level and the
  // pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/raster_dispatch.sv
// Raster dispatcher: queues set-up triangles, drops culled ones, and issues one
// triangle at a time to the rasterizer. Define CELERY_DISPATCH_STATS_EN for counters.
module raster_dispatch
  import celery_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  triangle_setup_t        s_tri,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   flush,
  output triangle_setup_t        r_tri,
  output logic                   r_start,
  input  logic                   r_done,
  input  logic                   r_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle,
  output logic [15:0]            cull_cnt,
  output logic [31:0]            tri_cnt,
  output logic [31:0]            run_cycles
);

  localparam int LW = $clog2(DEPTH) + 1;

  dispatch_state_t state_q;
  triangle_setup_t r_tri_q;
  triangle_setup_t head;
  logic            r_start_q;
  logic [15:0]     cull_q, cull_d;
  logic [LW-1:0]   level_w;
  logic            accept, push, pop;

  // Readiness looks only at the registered level, never at a same-cycle pop.
  assign s_ready = (level_w < LW'(DEPTH)) && !flush;
  assign accept  = s_valid && s_ready;
  assign push    = accept && s_tri.valid;
  assign pop     = (state_q == D_IDLE) && (level_w != '0) && !r_busy;

  tri_fifo #(
    .DEPTH (DEPTH),
    .T     (triangle_setup_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (s_tri),
    .pop       (pop),
    .flush     (flush),
    .level     (level_w),
    .head      (head)
  );

  // Flush only touches the queue; a triangle already popped runs to completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= D_IDLE;
      r_start_q <= 1'b0;
      r_tri_q   <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads this cycle's state
      // and the default below is overridden only by the issuing transition.
      r_start_q <= 1'b0;
      case (state_q)
        D_IDLE: begin
          if (pop) begin
            state_q   <= D_ISSUE;
            r_start_q <= 1'b1;
            r_tri_q   <= head;
          end
        end
        D_ISSUE: state_q <= D_RUN;
        D_RUN: begin
          if (r_done) begin
            state_q       <= D_IDLE;
            r_tri_q.valid <= 1'b0;
          end
        end
        default: state_q <= D_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves cull_d unassigned.
    cull_d = cull_q;
    if (accept && !s_tri.valid && (cull_q != 16'hFFFF)) cull_d = cull_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cull_q <= '0;
    else        cull_q <= cull_d;
  end

`ifdef CELERY_DISPATCH_STATS_EN
  logic [31:0] tri_cnt_q, run_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tri_cnt_q    <= '0;
      run_cycles_q <= '0;
    end else begin
      if (r_start_q)          tri_cnt_q    <= tri_cnt_q + 32'd1;
      if (state_q == D_RUN)   run_cycles_q <= run_cycles_q + 32'd1;
    end
  end

  assign tri_cnt    = tri_cnt_q;
  assign run_cycles = run_cycles_q;
`else
  assign tri_cnt    = '0;
  assign run_cycles = '0;
`endif

  assign r_tri    = r_tri_q;
  assign r_start  = r_start_q;
  assign level    = level_w;
  assign idle     = (level_w == '0) && (state_q == D_IDLE) && !r_busy;
  assign cull_cnt = cull_q;

endmodule

// File: tb/tb_raster_dispatch.sv
// Directed bench for raster_dispatch: a vector table for accept/cull/issue
// behaviour plus hand-written sequences for back-pressure, flush and reset.
module tb_raster_dispatch;
  import celery_pkg::*;

  localparam int DEPTH = 4;
  localparam int NV    = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  triangle_setup_t s_tri;
  logic            s_valid, s_ready, flush;
  triangle_setup_t r_tri;
  logic            r_start, r_done, r_busy, idle;
  logic [2:0]      level;
  logic [15:0]     cull_cnt;
  logic [31:0]     tri_cnt, run_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int issued[$];

  typedef struct {
    logic        sv;
    logic        tv;
    logic [11:0] id;
    logic        fl;
    logic        busy;
    logic        done;
    logic        rdy;
    logic [2:0]  lvl;
    logic        start;
    logic [11:0] rid;
    logic [15:0] cull;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  raster_dispatch #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tri      (s_tri),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .flush      (flush),
    .r_tri      (r_tri),
    .r_start    (r_start),
    .r_done     (r_done),
    .r_busy     (r_busy),
    .level      (level),
    .idle       (idle),
    .cull_cnt   (cull_cnt),
    .tri_cnt    (tri_cnt),
    .run_cycles (run_cycles)
  );

  // Record every issued triangle id, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && r_start) issued.push_back(int'(r_tri.tri_id));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic triangle_setup_t mk_tri(input logic v, input int id);
    triangle_setup_t t;
    t.valid  = v;
    t.tri_id = 12'(id);
    t.x0     = 16'(id * 3);
    t.y0     = 16'(id * 5 + 1);
    t.x1     = 16'(id * 7);
    t.y1     = 16'(id + 100);
    t.x2     = 16'(id * 11);
    t.y2     = 16'(id + 200);
    return t;
  endfunction

  task automatic drive(input logic v, input logic tv, input int id);
    s_valid = v;
    s_tri   = mk_tri(tv, id);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_tri   = '0;
    flush   = 1'b0;
    r_done  = 1'b0;
    r_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issued.delete();
  endtask

  // Rasterizer model: wait for D_RUN (valid triangle, no start pulse), run, then done.
  task automatic serve(input int run_len);
    int n = 0;
    while (!(r_tri.valid && !r_start) && n < 40) begin
      step();
      n++;
    end
    check("serve_wait_run", 128'(n < 40), 128'(1));
    repeat (run_len) step();
    r_done = 1'b1;
    step();
    r_done = 1'b0;
  endtask

  task automatic check_range(input string name, input int first, input int count);
    check({name, "_count"}, 128'(issued.size()), 128'(count));
    for (int i = 0; i < count && i < issued.size(); i++)
      check($sformatf("%s_%0d", name, i), 128'(issued[i]), 128'(first + i));
  endtask

  initial begin
    int exp_tri;
    int exp_run;
    int n;

    // sv tv id fl busy done | rdy lvl start rid cull
    vecs[0] = '{1'b1, 1'b0, 12'd10, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 12'd0,  16'd1};
    vecs[1] = '{1'b1, 1'b0, 12'd11, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 12'd0,  16'd2};
    vecs[2] = '{1'b1, 1'b0, 12'd12, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 12'd0,  16'd3};
    vecs[3] = '{1'b1, 1'b1, 12'd13, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 12'd0,  16'd3};
    vecs[4] = '{1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 12'd13, 16'd3};
    vecs[5] = '{1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 12'd0,  16'd3};
    vecs[6] = '{1'b0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 12'd0,  16'd3};
    vecs[7] = '{1'b1, 1'b1, 12'd14, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 12'd0,  16'd3};
    vecs[8] = '{1'b1, 1'b0, 12'd15, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 12'd0,  16'd4};

`ifdef CELERY_DISPATCH_STATS_EN
    exp_tri = 1;
    exp_run = 8;
`else
    exp_tri = 0;
    exp_run = 0;
`endif

    // Reset state
    do_reset();
    check("rst_level",   128'(level),    128'(0));
    check("rst_r_start", 128'(r_start),  128'(0));
    check("rst_r_tri",   128'(r_tri),    128'(0));
    check("rst_cull",    128'(cull_cnt), 128'(0));
    check("rst_idle",    128'(idle),     128'(1));
    check("rst_s_ready", 128'(s_ready),  128'(1));
    check("rst_tri_cnt", 128'(tri_cnt),  128'(0));
    check("rst_run_cyc", 128'(run_cycles), 128'(0));

    // Single triangle: push at cycle 0, start at cycle 2, done at 10, idle at 11
    drive(1'b1, 1'b1, 1);
    step();
    s_valid = 1'b0;
    check("t1_c1_level", 128'(level),   128'(1));
    check("t1_c1_start", 128'(r_start), 128'(0));
    step();
    check("t1_c2_start", 128'(r_start), 128'(1));
    check("t1_c2_r_tri", 128'(r_tri),   128'(mk_tri(1'b1, 1)));
    r_done = 1'b1;
    step();
    r_done = 1'b0;
    check("t1_c3_start", 128'(r_start),     128'(0));
    check("t1_c3_valid", 128'(r_tri.valid), 128'(1));
    repeat (7) step();
    check("t1_c10_valid", 128'(r_tri.valid), 128'(1));
    r_done = 1'b1;
    step();
    r_done = 1'b0;
    check("t1_c11_idle",  128'(idle),         128'(1));
    check("t1_c11_valid", 128'(r_tri.valid),  128'(0));
    check("t1_c11_id",    128'(r_tri.tri_id), 128'(1));
    check("t1_tri_cnt",   128'(tri_cnt),      128'(exp_tri));
    check("t1_run_cyc",   128'(run_cycles),   128'(exp_run));
    check_range("t1_order", 1, 1);

    // Vector table: culled triangles, one valid issue, flush rejecting a push
    do_reset();
    for (int i = 0; i < NV; i++) begin
      s_valid = vecs[i].sv;
      s_tri   = mk_tri(vecs[i].tv, int'(vecs[i].id));
      flush   = vecs[i].fl;
      r_busy  = vecs[i].busy;
      r_done  = vecs[i].done;
      #1;
      check($sformatf("v%0d_s_ready", i), 128'(s_ready), 128'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_level", i), 128'(level),    128'(vecs[i].lvl));
      check($sformatf("v%0d_start", i), 128'(r_start),  128'(vecs[i].start));
      check($sformatf("v%0d_cull", i),  128'(cull_cnt), 128'(vecs[i].cull));
      if (vecs[i].start) begin
        check($sformatf("v%0d_rid", i),   128'(r_tri.tri_id), 128'(vecs[i].rid));
        check($sformatf("v%0d_rval", i),  128'(r_tri.valid),  128'(1));
      end
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    r_busy  = 1'b0;
    r_done  = 1'b0;
    check_range("cull_order", 13, 1);

    // Back-pressure: queue fills while the rasterizer is stalled in D_RUN
    do_reset();
    drive(1'b1, 1'b1, 20);
    step();
    s_valid = 1'b0;
    repeat (2) step();
    r_busy = 1'b1;
    for (int id = 21; id <= 24; id++) begin
      drive(1'b1, 1'b1, id);
      step();
    end
    drive(1'b1, 1'b1, 25);
    #1;
    check("bp_full_level", 128'(level),   128'(4));
    check("bp_full_ready", 128'(s_ready), 128'(0));
    repeat (3) step();
    check("bp_hold_level", 128'(level),   128'(4));
    check("bp_hold_ready", 128'(s_ready), 128'(0));
    r_busy = 1'b0;
    r_done = 1'b1;
    step();
    r_done = 1'b0;
    n = 0;
    while (!s_ready && n < 10) begin
      step();
      n++;
    end
    check("bp_ready_again", 128'(s_ready), 128'(1));
    step();
    s_valid = 1'b0;
    check("bp_refill_level", 128'(level), 128'(4));
    repeat (5) serve(3);
    check("bp_idle", 128'(idle), 128'(1));
    check_range("bp_order", 20, 6);

    // Simultaneous push and pop at level 2, order over 6 triangles
    do_reset();
    drive(1'b1, 1'b1, 30);
    step();
    drive(1'b1, 1'b1, 31);
    step();
    drive(1'b1, 1'b1, 32);
    step();
    s_valid = 1'b0;
    check("pp_c3_level", 128'(level), 128'(2));
    r_done = 1'b1;
    step();
    r_done = 1'b0;
    drive(1'b1, 1'b1, 33);
    step();
    check("pp_same_level", 128'(level), 128'(2));
    drive(1'b1, 1'b1, 34);
    step();
    drive(1'b1, 1'b1, 35);
    step();
    s_valid = 1'b0;
    check("pp_c7_level", 128'(level), 128'(4));
    repeat (5) serve(2);
    check_range("pp_order", 30, 6);

    // Flush with level 3 while D_RUN
    do_reset();
    for (int id = 40; id <= 43; id++) begin
      drive(1'b1, 1'b1, id);
      step();
    end
    check("fl_pre_level", 128'(level), 128'(3));
    flush = 1'b1;
    drive(1'b1, 1'b1, 44);
    #1;
    check("fl_ready", 128'(s_ready), 128'(0));
    step();
    flush   = 1'b0;
    s_valid = 1'b0;
    check("fl_level",   128'(level),        128'(0));
    check("fl_cur_id",  128'(r_tri.tri_id), 128'(40));
    check("fl_cur_val", 128'(r_tri.valid),  128'(1));
    serve(2);
    repeat (20) step();
    check("fl_idle", 128'(idle), 128'(1));
    check_range("fl_order", 40, 1);

    // Flush coinciding with a pop in D_IDLE still issues the popped triangle
    do_reset();
    r_busy = 1'b1;
    drive(1'b1, 1'b1, 50);
    step();
    drive(1'b1, 1'b1, 51);
    step();
    s_valid = 1'b0;
    check("fp_pre_level", 128'(level), 128'(2));
    r_busy = 1'b0;
    flush  = 1'b1;
    step();
    flush = 1'b0;
    check("fp_level", 128'(level),        128'(0));
    check("fp_start", 128'(r_start),      128'(1));
    check("fp_id",    128'(r_tri.tri_id), 128'(50));
    serve(1);
    repeat (5) step();
    check_range("fp_order", 50, 1);

    // Reset asserted in D_RUN with level 2
    do_reset();
    drive(1'b1, 1'b1, 60);
    step();
    drive(1'b1, 1'b1, 61);
    step();
    drive(1'b1, 1'b1, 62);
    step();
    s_valid = 1'b0;
    check("mr_pre_level", 128'(level), 128'(2));
    rst_n = 1'b0;
    #1;
    check("mr_level",   128'(level),      128'(0));
    check("mr_start",   128'(r_start),    128'(0));
    check("mr_r_tri",   128'(r_tri),      128'(0));
    check("mr_idle",    128'(idle),       128'(1));
    check("mr_tri_cnt", 128'(tri_cnt),    128'(0));
    check("mr_run_cyc", 128'(run_cycles), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issued.delete();
    repeat (20) step();
    check("mr_no_start", 128'(issued.size()), 128'(0));
    check("mr_post_level", 128'(level), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
